// File: rtl/commit_unit_if.sv
// Commit-stage bus between the ROB head / memory / register file and commit_unit.
// master = surrounding pipeline (drives the head entry and st_ack), slave = commit_unit.

`ifndef COMMIT_UNIT_DEFS
`define COMMIT_UNIT_DEFS
`define ROB_ID_WIDTH 4
`define AluOpBus     7:0
`define RegAddrBus   4:0
`define RegBus       31:0
`define InstAddrBus  31:0
`define ALU_OP_ADD   8'h01
`define ALU_OP_SUB   8'h02
`define ALU_OP_LUI   8'h05
`define ALU_OP_BEQ   8'h10
`define ALU_OP_BNE   8'h11
`define ALU_OP_BLT   8'h12
`define ALU_OP_BGE   8'h13
`define ALU_OP_BLTU  8'h14
`define ALU_OP_BGEU  8'h15
`define ALU_OP_SB    8'h18
`define ALU_OP_SH    8'h19
`define ALU_OP_SW    8'h1A
`define ALU_OP_JALR  8'h1C
`endif

interface commit_unit_if;
    logic                     head_valid;
    logic [`ROB_ID_WIDTH-1:0] head_id;
    logic [`AluOpBus]         head_op;
    logic [`RegAddrBus]       head_rd;
    logic [`RegBus]           head_value;
    logic [`InstAddrBus]      head_pc;
    logic [`InstAddrBus]      head_addr;
    logic                     head_pred;
    logic                     head_outcome;
    logic [`InstAddrBus]      head_pred_target;
    logic                     commit_ack;
    logic                     rf_we;
    logic [4:0]               rf_waddr;
    logic [31:0]              rf_wdata;
    logic [`ROB_ID_WIDTH-1:0] rf_rob_id;
    logic                     st_req;
    logic [31:0]              st_addr;
    logic [31:0]              st_data;
    logic [1:0]               st_size;
    logic                     st_ack;
    logic                     flush;
    logic [`InstAddrBus]      redirect_pc;
    logic [63:0]              instret;

    modport master (
        output head_valid, head_id, head_op, head_rd, head_value, head_pc, head_addr,
               head_pred, head_outcome, head_pred_target, st_ack,
        input  commit_ack, rf_we, rf_waddr, rf_wdata, rf_rob_id, st_req, st_addr,
               st_data, st_size, flush, redirect_pc, instret
    );

    modport slave (
        input  head_valid, head_id, head_op, head_rd, head_value, head_pc, head_addr,
               head_pred, head_outcome, head_pred_target, st_ack,
        output commit_ack, rf_we, rf_waddr, rf_wdata, rf_rob_id, st_req, st_addr,
               st_data, st_size, flush, redirect_pc, instret
    );
endinterface

// File: rtl/commit_unit.sv
// In-order single-retire commit stage: register writeback, store handshake, mispredict flush.
// Optional retired-instruction counter enabled by defining COMMIT_INSTRET_EN.

`ifndef COMMIT_UNIT_DEFS
`define COMMIT_UNIT_DEFS
`define ROB_ID_WIDTH 4
`define AluOpBus     7:0
`define RegAddrBus   4:0
`define RegBus       31:0
`define InstAddrBus  31:0
`define ALU_OP_ADD   8'h01
`define ALU_OP_SUB   8'h02
`define ALU_OP_LUI   8'h05
`define ALU_OP_BEQ   8'h10
`define ALU_OP_BNE   8'h11
`define ALU_OP_BLT   8'h12
`define ALU_OP_BGE   8'h13
`define ALU_OP_BLTU  8'h14
`define ALU_OP_BGEU  8'h15
`define ALU_OP_SB    8'h18
`define ALU_OP_SH    8'h19
`define ALU_OP_SW    8'h1A
`define ALU_OP_JALR  8'h1C
`endif

module commit_unit (
    input  logic         clk,
    input  logic         rst,
    commit_unit_if.slave bus
);
    typedef enum logic [1:0] {RUN, ST_WAIT, FLUSH} state_t;

    state_t              state_reg;
    logic                st_req_reg;
    logic [31:0]         st_addr_reg;
    logic [31:0]         st_data_reg;
    logic [1:0]          st_size_reg;
    logic                flush_reg;
    logic [`InstAddrBus] redirect_reg;

    logic is_branch, is_store, is_jalr, mispredict, writes_rd, run_now;
    logic [1:0] op_size;

    assign is_branch = (bus.head_op >= `ALU_OP_BEQ) && (bus.head_op <= `ALU_OP_BGEU);
    assign is_store  = (bus.head_op == `ALU_OP_SB) || (bus.head_op == `ALU_OP_SH) ||
                       (bus.head_op == `ALU_OP_SW);
    assign is_jalr   = (bus.head_op == `ALU_OP_JALR);
    assign writes_rd = !is_branch && !is_store && (bus.head_rd != 5'd0);
    assign op_size   = (bus.head_op == `ALU_OP_SB) ? 2'd0 :
                       (bus.head_op == `ALU_OP_SH) ? 2'd1 : 2'd2;

    // A taken branch must also have gone to the right place.
    always_comb begin
        mispredict = 1'b0;
        if (is_branch)
            mispredict = (bus.head_pred != bus.head_outcome) ||
                         (bus.head_outcome && (bus.head_pred_target != bus.head_addr));
        else if (is_jalr)
            mispredict = (bus.head_pred_target != bus.head_addr);
    end

    // rst gates the combinational path so outputs read zero while reset is held.
    assign run_now = rst && (state_reg == RUN) && bus.head_valid;

    always_comb begin
        bus.commit_ack = 1'b0;
        bus.rf_we      = 1'b0;
        bus.rf_waddr   = 5'd0;
        bus.rf_wdata   = 32'd0;
        bus.rf_rob_id  = '0;
        bus.st_req     = st_req_reg;
        bus.st_addr    = st_addr_reg;
        bus.st_data    = st_data_reg;
        bus.st_size    = st_size_reg;
        if (run_now) begin
            if (writes_rd) begin
                bus.rf_we     = 1'b1;
                bus.rf_waddr  = bus.head_rd;
                bus.rf_wdata  = bus.head_value;
                bus.rf_rob_id = bus.head_id;
            end
            if (is_store) begin
                bus.st_req     = 1'b1;
                bus.st_addr    = bus.head_addr;
                bus.st_data    = bus.head_value;
                bus.st_size    = op_size;
                bus.commit_ack = bus.st_ack;
            end else begin
                bus.commit_ack = !mispredict;
            end
        end else if (rst && (state_reg == ST_WAIT)) begin
            bus.commit_ack = bus.st_ack;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= RUN;
            st_req_reg   <= 1'b0;
            st_addr_reg  <= 32'd0;
            st_data_reg  <= 32'd0;
            st_size_reg  <= 2'd0;
            flush_reg    <= 1'b0;
            redirect_reg <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (bus.head_valid) begin
                        if (is_store) begin
                            if (!bus.st_ack) begin
                                state_reg   <= ST_WAIT;
                                st_req_reg  <= 1'b1;
                                st_addr_reg <= bus.head_addr;
                                st_data_reg <= bus.head_value;
                                st_size_reg <= op_size;
                            end
                        end else if (mispredict) begin
                            state_reg    <= FLUSH;
                            flush_reg    <= 1'b1;
                            redirect_reg <= (is_jalr || (is_branch && bus.head_outcome)) ?
                                            bus.head_addr : bus.head_pc + 32'd4;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.st_ack) begin
                        state_reg  <= RUN;
                        st_req_reg <= 1'b0;
                    end
                end
                FLUSH: begin
                    state_reg <= RUN;
                    flush_reg <= 1'b0;
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    assign bus.flush       = flush_reg;
    assign bus.redirect_pc = redirect_reg;

`ifdef COMMIT_INSTRET_EN
    logic [63:0] instret_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            instret_reg <= 64'd0;
        else if (bus.commit_ack)
            instret_reg <= instret_reg + 64'd1;
    end

    assign bus.instret = instret_reg;
`else
    assign bus.instret = 64'd0;
`endif

endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 head_valid  input  1  ROB head entry ready to retire.
REQ-004 head_id  input  `ROB_ID_WIDTH  ROB index of head.
REQ-005 head_op  input  `AluOpBus  operation class of head.
REQ-006 head_rd / head_value  input  `RegAddrBus / `RegBus  destination register and result; store data for stores.
REQ-007 head_pc / head_addr  input  `InstAddrBus  instruction PC; resolved target (branch/JALR) or effective address (store).
REQ-008 head_pred / head_outcome / head_pred_target  input  1/1/`InstAddrBus  prediction, actual direction, predicted target.
REQ-009 commit_ack  output  1  retire head this cycle (ROB pops head).
REQ-010 rf_we / rf_waddr / rf_wdata / rf_rob_id  output  1/5/32/`ROB_ID_WIDTH  architectural register write; rf_rob_id lets the register file clear a matching rename tag.
REQ-011 st_req / st_addr / st_data / st_size  output  1/32/32/2  store-to-memory request; size 0=byte, 1=half, 2=word.
REQ-012 st_ack  input  1  memory accepted the store.
REQ-013 flush / redirect_pc  output  1/`InstAddrBus  global pipeline flush and fetch restart PC.
REQ-014 instret  output  64  retired-instruction count (see Configuration).

Function
REQ-015 States: RUN, ST_WAIT, FLUSH; reset state RUN.
REQ-016 Branch = ALU_OP_BEQ..ALU_OP_BGEU; store = ALU_OP_SB/SH/SW; jump-indirect = ALU_OP_JALR; all other ops are register-writing.
REQ-017 Mispredict: branch with pred!=outcome, or branch taken with pred_target!=addr; JALR with pred_target!=addr.
REQ-018 RUN, head_valid, non-store, not mispredicted: commit_ack=1 combinationally, same cycle.
REQ-019 rf_we=1 in the commit_ack cycle for register-writing ops and JALR when head_rd!=0; rf_waddr=head_rd, rf_wdata=head_value, rf_rob_id=head_id; never for branches, stores, or rd=0.
REQ-020 RUN, head_valid, mispredicted: commit_ack=0; JALR still writes rd per REQ-019 this cycle; next state FLUSH.
REQ-021 FLUSH lasts exactly one cycle: flush=1 registered, redirect_pc = head_addr if taken/JALR else head_pc+4, captured at detection; commit_ack=0; next state RUN.
REQ-022 Mispredicted head is never acked; ROB discards it on flush.
REQ-023 RUN, head_valid, store: st_req=1, state ST_WAIT; st_addr=head_addr, st_data=head_value, st_size from op, held stable until st_ack.
REQ-024 ST_WAIT: commit_ack=1 in the same cycle st_ack=1, then RUN; st_req deasserts the following cycle. st_ack in RUN is ignored.
REQ-025 st_ack in the same cycle st_req first rises retires the store that cycle (one-cycle store).
REQ-026 At most one instruction retires per cycle; head_valid=0 produces no outputs.
REQ-027 redirect_pc arithmetic modulo 2^32; head_pc=0xFFFFFFFC, not taken -> 0x00000000.

Reset
REQ-028 Asserting rst at any time, including ST_WAIT or FLUSH, forces RUN immediately; commit_ack, rf_we, st_req, flush=0; redirect_pc, st_addr, st_data, st_size=0; instret=0.
REQ-029 A store pending in ST_WAIT at reset is abandoned; a late st_ack is ignored.

Configuration
REQ-030 Macro COMMIT_INSTRET_EN: defined -> instret increments by 1 every commit_ack cycle, wraps at 2^64, survives flush, cleared only by reset.
REQ-031 Not defined -> instret is constant 0 and no counter register exists.

Verification
REQ-032 ADD head rd=5, value=0x1234 valid -> same-cycle commit_ack=1, rf_we=1, rf_waddr=5, rf_wdata=0x1234.
REQ-033 BEQ pc=0x100 pred=1 outcome=0 -> commit_ack=0; next cycle flush=1 for one cycle, redirect_pc=0x104; no rf_we.
REQ-034 SW addr=0x2000 data=0xDEADBEEF, st_ack after 3 cycles -> st_req=1 held 3 cycles, st_size=2, commit_ack=1 only in st_ack cycle.
REQ-035 JALR rd=1 value=0x108 pred_target=0x300 addr=0x400 -> rf_we=1 rd=1, commit_ack=0, next cycle flush=1 redirect_pc=0x400.
REQ-036 Reset asserted mid ST_WAIT, then st_ack -> st_req=0 immediately, no commit_ack; with COMMIT_INSTRET_EN, instret=0 after reset and 10 after 10 ADD retires.
